nios_keycode_queue: RTL

- Parametrised successor to the single-register keycode output PIO: an Avalon-MM slave that buffers host-written keycodes in a DEPTH-entry FIFO.
- Hardware consumers drain the FIFO over a valid/ready stream, so bursts of keypresses from the NIOS USB handler are no longer lost when the game logic samples slowly.
- Adds status, flush, a low-watermark interrupt and a last-consumed register.

---
 rtl/nios_keycode_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/nios_keycode_queue.sv
// Avalon-MM keycode FIFO with valid/ready drain, status, flush, low-watermark irq and last-popped register.
// Optional: define NIOS_KEYCODE_QUEUE_HOLD_LAST_EN to present the last popped keycode on out_data while empty.
module nios_keycode_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LOW_WM = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LOW_WM_C = CNT_W'(LOW_WM);

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CONTROL = 2'd2, A_LAST = 2'd3;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow, r_irq_en, r_irq;
  logic [DATA_W-1:0] r_last;

  logic              w_wr, w_push, w_flush, w_pop, w_push_ok;
  logic              w_empty, w_full;
  logic [DATA_W-1:0] w_head;

  assign w_wr      = chipselect & ~write_n;
  assign w_push    = w_wr & (address == A_DATA);
  assign w_flush   = w_wr & (address == A_CONTROL) & writedata[1];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_pop     = out_valid & out_ready;
  // A full queue still accepts a push when the consumer frees a slot on the same edge.
  assign w_push_ok = w_push & (~w_full | w_pop);

  assign out_valid = ~w_empty;
  assign irq       = r_irq;

`ifdef NIOS_KEYCODE_QUEUE_HOLD_LAST_EN
  assign out_data = w_empty ? r_last : w_head;
`else
  assign out_data = w_empty ? '0 : w_head;
`endif

  always_ff @(posedge clk) begin
    if (w_push_ok && !w_flush)
      r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq      <= 1'b0;
      r_last     <= '0;
    end else begin
      // Flush discards any concurrent push or pop, including the last update.
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_last   <= w_head;
        end
        if (w_push_ok)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_push && !w_push_ok)
          r_overflow <= 1'b1;
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      if (w_wr && (address == A_STATUS) && writedata[2])
        r_overflow <= 1'b0;
      if (w_wr && (address == A_CONTROL))
        r_irq_en <= writedata[0];
      r_irq <= r_irq_en & (r_count <= LOW_WM_C);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:    readdata[DATA_W-1:0] = w_empty ? '0 : w_head;
      A_STATUS: begin
        readdata[0]          = w_empty;
        readdata[1]          = w_full;
        readdata[2]          = r_overflow;
        readdata[8 +: CNT_W] = r_count;
      end
      A_CONTROL: readdata[0] = r_irq_en;
      A_LAST:    readdata[DATA_W-1:0] = r_last;
      default:   readdata = '0;
    endcase
  end
endmodule
